// File: rtl/sram_arb_pkg.sv
// Shared types and constants for the two-port SRAM arbiter.
package sram_arb_pkg;

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_e;
   typedef enum logic {OP_RD, OP_WR} op_e;

   localparam logic REQ_A = 1'b0;
   localparam logic REQ_B = 1'b1;

   // Holds READ_LATENCY-1 for latencies 1..4.
   localparam int CNT_W = 2;

endpackage

// File: rtl/sram_arb_pick.sv
// Combinational winner select for the SRAM arbiter.
// SRAM_ARB_FIXED_PRIORITY_EN: A wins ties; otherwise the non-last winner wins.
module sram_arb_pick
   import sram_arb_pkg::*;
(
   input  logic a_req,
   input  logic b_req,
   input  logic last_winner,
   output logic valid,
   output logic winner
);

   assign valid = a_req | b_req;

`ifdef SRAM_ARB_FIXED_PRIORITY_EN
   logic unused_last;
   assign unused_last = last_winner;
   assign winner      = a_req ? REQ_A : REQ_B;
`else
   always_comb begin
      if (a_req && b_req) winner = (last_winner == REQ_A) ? REQ_B : REQ_A;
      else                winner = a_req ? REQ_A : REQ_B;
   end
`endif

endmodule

// File: rtl/sram_arbiter.sv
// Two-requester arbiter sharing one SRAM controller; Avalon-style waitrequest.
// SRAM_ARB_FIXED_PRIORITY_EN selects fixed A-priority instead of round-robin.
module sram_arbiter
   import sram_arb_pkg::*;
#(
   parameter int ADDR_W       = 18,
   parameter int DATA_W       = 16,
   parameter int READ_LATENCY = 1
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic [ADDR_W-1:0] a_address,
   input  logic [1:0]        a_byte_enable,
   input  logic              a_read,
   input  logic              a_write,
   input  logic [DATA_W-1:0] a_write_data,
   output logic [DATA_W-1:0] a_read_data,
   output logic              a_waitrequest,
   input  logic [ADDR_W-1:0] b_address,
   input  logic [1:0]        b_byte_enable,
   input  logic              b_read,
   input  logic              b_write,
   input  logic [DATA_W-1:0] b_write_data,
   output logic [DATA_W-1:0] b_read_data,
   output logic              b_waitrequest,
   output logic [ADDR_W-1:0] s_address,
   output logic              s_chipselect,
   output logic [1:0]        s_byte_enable,
   output logic              s_read,
   output logic              s_write,
   output logic [DATA_W-1:0] s_write_data,
   input  logic [DATA_W-1:0] s_read_data,
   output logic              grant_b
);

   logic a_req, b_req, pick_valid, pick_win, win_b, win_wr, last_winner, complete;
   state_e state_q, state_d;
   op_e op_q, op_d;
   logic owner_q, owner_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic s_cs_q, s_cs_d, s_rd_q, s_rd_d, s_wr_q, s_wr_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [1:0] be_q, be_d;
   logic [DATA_W-1:0] wdata_q, wdata_d, a_rdata_q, a_rdata_d, b_rdata_q, b_rdata_d;
   logic a_done_q, a_done_d, b_done_q, b_done_d, grant_b_q, grant_b_d;

   assign a_req = a_read | a_write;
   assign b_req = b_read | b_write;

   sram_arb_pick u_pick (
      .a_req       (a_req),
      .b_req       (b_req),
      .last_winner (last_winner),
      .valid       (pick_valid),
      .winner      (pick_win)
   );

   assign win_b  = (pick_win == REQ_B);
   assign win_wr = win_b ? b_write : a_write;

   always_comb begin
      state_d   = state_q;
      op_d      = op_q;
      owner_d   = owner_q;
      cnt_d     = cnt_q;
      s_cs_d    = s_cs_q;
      s_rd_d    = 1'b0;
      s_wr_d    = 1'b0;
      addr_d    = addr_q;
      be_d      = be_q;
      wdata_d   = wdata_q;
      a_rdata_d = a_rdata_q;
      b_rdata_d = b_rdata_q;
      a_done_d  = 1'b0;
      b_done_d  = 1'b0;
      grant_b_d = grant_b_q;
      complete  = 1'b0;
      case (state_q)
         IDLE: if (pick_valid) begin
            owner_d   = pick_win;
            op_d      = win_wr ? OP_WR : OP_RD;
            addr_d    = win_b ? b_address : a_address;
            be_d      = win_b ? b_byte_enable : a_byte_enable;
            wdata_d   = win_b ? b_write_data : a_write_data;
            s_cs_d    = 1'b1;
            s_wr_d    = win_wr;
            s_rd_d    = ~win_wr;
            // A write completes in the very cycle it is issued.
            a_done_d  = win_wr & ~win_b;
            b_done_d  = win_wr & win_b;
            grant_b_d = win_b;
            state_d   = ISSUE;
         end
         ISSUE: begin
            if (op_q == OP_WR) begin
               s_cs_d    = 1'b0;
               grant_b_d = 1'b0;
               complete  = 1'b1;
               state_d   = IDLE;
            end else begin
               cnt_d   = CNT_W'(READ_LATENCY - 1);
               state_d = WAIT;
            end
         end
         WAIT: begin
            if (cnt_q == '0) begin
               // A requester that abandoned its read does not get the word.
               if (owner_q == REQ_B) begin
                  if (b_read && !b_write) b_rdata_d = s_read_data;
                  b_done_d = 1'b1;
               end else begin
                  if (a_read && !a_write) a_rdata_d = s_read_data;
                  a_done_d = 1'b1;
               end
               s_cs_d  = 1'b0;
               state_d = RESP;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         RESP: begin
            grant_b_d = 1'b0;
            complete  = 1'b1;
            state_d   = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= IDLE;
         op_q      <= OP_RD;
         owner_q   <= REQ_A;
         cnt_q     <= '0;
         s_cs_q    <= 1'b0;
         s_rd_q    <= 1'b0;
         s_wr_q    <= 1'b0;
         addr_q    <= '0;
         be_q      <= '0;
         wdata_q   <= '0;
         a_rdata_q <= '0;
         b_rdata_q <= '0;
         a_done_q  <= 1'b0;
         b_done_q  <= 1'b0;
         grant_b_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         op_q      <= op_d;
         owner_q   <= owner_d;
         cnt_q     <= cnt_d;
         s_cs_q    <= s_cs_d;
         s_rd_q    <= s_rd_d;
         s_wr_q    <= s_wr_d;
         addr_q    <= addr_d;
         be_q      <= be_d;
         wdata_q   <= wdata_d;
         a_rdata_q <= a_rdata_d;
         b_rdata_q <= b_rdata_d;
         a_done_q  <= a_done_d;
         b_done_q  <= b_done_d;
         grant_b_q <= grant_b_d;
      end
   end

`ifdef SRAM_ARB_FIXED_PRIORITY_EN
   logic unused_complete;
   assign unused_complete = complete;
   assign last_winner     = REQ_B;
`else
   logic last_q, last_d;
   always_comb last_d = complete ? owner_q : last_q;
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) last_q <= REQ_B;
      else          last_q <= last_d;
   end
   assign last_winner = last_q;
`endif

   assign a_waitrequest = a_req & ~a_done_q;
   assign b_waitrequest = b_req & ~b_done_q;
   assign a_read_data   = a_rdata_q;
   assign b_read_data   = b_rdata_q;
   assign s_address     = addr_q;
   assign s_chipselect  = s_cs_q;
   assign s_byte_enable = be_q;
   assign s_read        = s_rd_q;
   assign s_write       = s_wr_q;
   assign s_write_data  = wdata_q;
   assign grant_b       = grant_b_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// Bench for sram_arbiter: one instance at READ_LATENCY=1, one at 3, each with an SRAM stub.
module tb_sram_arbiter;
   localparam int AW   = 18;
   localparam int DW   = 16;
   localparam int NDUT = 2;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   always #5 clk = ~clk;

   logic [AW-1:0]   a_addr [NDUT], b_addr [NDUT], s_addr [NDUT];
   logic [1:0]      a_be [NDUT], b_be [NDUT], s_be [NDUT];
   logic [DW-1:0]   a_wd [NDUT], b_wd [NDUT], a_rdat [NDUT], b_rdat [NDUT], s_wd [NDUT], s_rdat [NDUT];
   logic [NDUT-1:0] a_rd, a_wr, b_rd, b_wr, a_wait, b_wait, s_cs, s_rd, s_wr, gnt_b;
   logic [DW-1:0]   held_a [NDUT], held_b [NDUT];
   logic [DW-1:0]   ref_mem [int];
   int total = 0;
   int bad = 0;

   function automatic logic [DW-1:0] dflt(input logic [AW-1:0] a);
      return a[15:0] ^ 16'h5A5A;
   endfunction

   function automatic logic [DW-1:0] merge(input logic [DW-1:0] old, input logic [DW-1:0] d,
                                           input logic [1:0] be);
      return {be[1] ? d[15:8] : old[15:8], be[0] ? d[7:0] : old[7:0]};
   endfunction

   for (genvar g = 0; g < NDUT; g++) begin : g_dut
      localparam int RL = (g == 0) ? 1 : 3;
      logic [DW-1:0] mem [0:(1<<AW)-1];
      logic [DW-1:0] pipe [RL];

      initial for (int i = 0; i < (1 << AW); i++) mem[i] = dflt(AW'(i));

      sram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .READ_LATENCY(RL)) u_dut (
         .clk(clk), .reset_n(reset_n),
         .a_address(a_addr[g]), .a_byte_enable(a_be[g]), .a_read(a_rd[g]), .a_write(a_wr[g]),
         .a_write_data(a_wd[g]), .a_read_data(a_rdat[g]), .a_waitrequest(a_wait[g]),
         .b_address(b_addr[g]), .b_byte_enable(b_be[g]), .b_read(b_rd[g]), .b_write(b_wr[g]),
         .b_write_data(b_wd[g]), .b_read_data(b_rdat[g]), .b_waitrequest(b_wait[g]),
         .s_address(s_addr[g]), .s_chipselect(s_cs[g]), .s_byte_enable(s_be[g]),
         .s_read(s_rd[g]), .s_write(s_wr[g]), .s_write_data(s_wd[g]),
         .s_read_data(s_rdat[g]), .grant_b(gnt_b[g])
      );

      // Controller stub: data valid RL cycles after s_read, garbage otherwise.
      assign s_rdat[g] = pipe[RL-1];
      always @(posedge clk) begin
         pipe[0] <= s_rd[g] ? mem[s_addr[g]] : 16'hDEAD;
         for (int i = 1; i < RL; i++) pipe[i] <= pipe[i-1];
         if (s_wr[g]) mem[s_addr[g]] <= merge(mem[s_addr[g]], s_wd[g], s_be[g]);
      end
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h want 0x%0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic idle_all();
      for (int d = 0; d < NDUT; d++) begin
         a_rd[d] = 0; a_wr[d] = 0; b_rd[d] = 0; b_wr[d] = 0;
         a_addr[d] = '0; b_addr[d] = '0; a_be[d] = '0; b_be[d] = '0; a_wd[d] = '0; b_wd[d] = '0;
      end
   endtask

   // Leaves the bench one tick after a rising edge with the arbiter idle.
   task automatic do_reset();
      idle_all();
      reset_n = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk) reset_n = 1'b1;
      @(posedge clk); #1;
      for (int d = 0; d < NDUT; d++) begin held_a[d] = '0; held_b[d] = '0; end
   endtask

   typedef struct {
      int            d;
      bit            who_b;
      bit            wr;
      bit            rd_too;
      logic [AW-1:0] addr;
      logic [1:0]    be;
      logic [DW-1:0] wdata;
      int            exp_lat;
      logic [DW-1:0] exp_rdata;
   } vec_t;

   task automatic run_vec(input vec_t v);
      int lat = -1;
      logic wt;
      if (v.who_b) begin
         b_addr[v.d] = v.addr; b_be[v.d] = v.be; b_wd[v.d] = v.wdata;
         b_wr[v.d] = v.wr; b_rd[v.d] = !v.wr || v.rd_too;
      end else begin
         a_addr[v.d] = v.addr; a_be[v.d] = v.be; a_wd[v.d] = v.wdata;
         a_wr[v.d] = v.wr; a_rd[v.d] = !v.wr || v.rd_too;
      end
      for (int c = 0; c < 16; c++) begin
         #1;
         if (c == 1) begin
            chk("issue_cs", 32'(s_cs[v.d]), 32'd1);
            chk("issue_wr", 32'(s_wr[v.d]), 32'(v.wr));
            chk("issue_rd", 32'(s_rd[v.d]), 32'(!v.wr));
            chk("issue_addr", 32'(s_addr[v.d]), 32'(v.addr));
            chk("issue_be", 32'(s_be[v.d]), 32'(v.be));
            chk("issue_grant_b", 32'(gnt_b[v.d]), 32'(v.who_b));
            if (v.wr) chk("issue_wdata", 32'(s_wd[v.d]), 32'(v.wdata));
         end
         wt = v.who_b ? b_wait[v.d] : a_wait[v.d];
         if (!wt) begin lat = c; break; end
         @(posedge clk); #1;
      end
      chk("latency", 32'(lat), 32'(v.exp_lat));
      if (!v.wr) begin
         if (v.who_b) held_b[v.d] = v.exp_rdata;
         else         held_a[v.d] = v.exp_rdata;
      end
      chk("a_read_data", 32'(a_rdat[v.d]), 32'(held_a[v.d]));
      chk("b_read_data", 32'(b_rdat[v.d]), 32'(held_b[v.d]));
      @(posedge clk); #1;
      idle_all();
   endtask

   // Transaction-level reference: each grant occupies the bus from the IDLE
   // decision cycle k until k+1 (write) or k+2+RL (read), then one bubble.
   task automatic rand_run(input int d, input int ncyc);
      int rl = (d == 0) ? 1 : 3;
      bit act [2], opw [2], both [2];
      logic [AW-1:0] ad [2];
      logic [1:0] be [2];
      logic [DW-1:0] wd [2], exp_rd [2];
      int free_at = 0, comp = -1, gstart = -1, key;
      bit owner = 0, gop = 0, last = 1, win;
      exp_rd[0] = '0; exp_rd[1] = '0;
      act[0] = 0; act[1] = 0;
      do_reset();
      for (int k = 0; k < ncyc; k++) begin
         for (int x = 0; x < 2; x++) if (!act[x] && $urandom_range(0, 2) != 0) begin
            act[x]  = 1;
            opw[x]  = 1'($urandom_range(0, 1));
            both[x] = ($urandom_range(0, 5) == 0);
            ad[x]   = AW'(18'h100 + $urandom_range(0, 7));
            be[x]   = 2'($urandom_range(0, 3));
            wd[x]   = 16'($urandom);
         end
         a_rd[d] = act[0] && (!opw[0] || both[0]); a_wr[d] = act[0] && opw[0];
         b_rd[d] = act[1] && (!opw[1] || both[1]); b_wr[d] = act[1] && opw[1];
         a_addr[d] = ad[0]; a_be[d] = be[0]; a_wd[d] = wd[0];
         b_addr[d] = ad[1]; b_be[d] = be[1]; b_wd[d] = wd[1];
         #1;
         if (k == comp) begin
            key = (d << AW) + int'(ad[owner]);
            if (gop) ref_mem[key] = merge(ref_mem.exists(key) ? ref_mem[key] : dflt(ad[owner]),
                                          wd[owner], be[owner]);
            else     exp_rd[owner] = ref_mem.exists(key) ? ref_mem[key] : dflt(ad[owner]);
            last = owner;
         end
         chk("rnd_a_wait", 32'(a_wait[d]), 32'(act[0] && !(k == comp && owner == 0)));
         chk("rnd_b_wait", 32'(b_wait[d]), 32'(act[1] && !(k == comp && owner == 1)));
         chk("rnd_grant_b", 32'(gnt_b[d]), 32'(k >= gstart && k <= comp && owner == 1));
         chk("rnd_a_rdata", 32'(a_rdat[d]), 32'(exp_rd[0]));
         chk("rnd_b_rdata", 32'(b_rdat[d]), 32'(exp_rd[1]));
         if (k == comp) act[owner] = 0;
         if (k >= free_at && (act[0] || act[1])) begin
`ifdef SRAM_ARB_FIXED_PRIORITY_EN
            win = act[0] ? 1'b0 : 1'b1;
`else
            win = (act[0] && act[1]) ? !last : act[1];
`endif
            owner   = win;
            gop     = opw[win];
            gstart  = k + 1;
            comp    = k + (gop ? 1 : 2 + rl);
            free_at = comp + 1;
         end
         @(posedge clk); #1;
      end
      idle_all();
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t tbl [12];
      vec_t v;
      int order [$];
      int exp_order [4];

      tbl[0]  = '{0, 1'b0, 1'b1, 1'b0, 18'h00010, 2'b11, 16'hBEEF, 1, 16'h0000};
      tbl[1]  = '{0, 1'b0, 1'b0, 1'b0, 18'h00010, 2'b11, 16'h0000, 3, 16'hBEEF};
      tbl[2]  = '{0, 1'b1, 1'b0, 1'b0, 18'h00010, 2'b11, 16'h0000, 3, 16'hBEEF};
      tbl[3]  = '{0, 1'b1, 1'b1, 1'b0, 18'h3FFFF, 2'b01, 16'h12AB, 1, 16'h0000};
      tbl[4]  = '{0, 1'b1, 1'b0, 1'b0, 18'h3FFFF, 2'b11, 16'h0000, 3, 16'hA5AB};
      tbl[5]  = '{0, 1'b0, 1'b1, 1'b0, 18'h00020, 2'b10, 16'h77CC, 1, 16'h0000};
      tbl[6]  = '{0, 1'b0, 1'b0, 1'b0, 18'h00020, 2'b11, 16'h0000, 3, 16'h777A};
      tbl[7]  = '{1, 1'b1, 1'b1, 1'b0, 18'h3FFFF, 2'b01, 16'h12AB, 1, 16'h0000};
      tbl[8]  = '{1, 1'b1, 1'b0, 1'b0, 18'h3FFFF, 2'b11, 16'h0000, 5, 16'hA5AB};
      tbl[9]  = '{1, 1'b0, 1'b0, 1'b0, 18'h00005, 2'b11, 16'h0000, 5, 16'h5A5F};
      tbl[10] = '{1, 1'b0, 1'b1, 1'b1, 18'h00005, 2'b11, 16'h1234, 1, 16'h0000};
      tbl[11] = '{1, 1'b0, 1'b0, 1'b0, 18'h00005, 2'b11, 16'h0000, 5, 16'h1234};

      do_reset();
      for (int d = 0; d < NDUT; d++) begin
         chk("rst_cs", 32'(s_cs[d]), 32'd0);
         chk("rst_rd", 32'(s_rd[d]), 32'd0);
         chk("rst_wr", 32'(s_wr[d]), 32'd0);
         chk("rst_addr", 32'(s_addr[d]), 32'd0);
         chk("rst_grant_b", 32'(gnt_b[d]), 32'd0);
         chk("rst_a_rdata", 32'(a_rdat[d]), 32'd0);
         chk("rst_b_rdata", 32'(b_rdat[d]), 32'd0);
         chk("rst_a_wait", 32'(a_wait[d]), 32'd0);
      end

      for (int i = 0; i < 12; i++) run_vec(tbl[i]);

      // Both requesters hold reads continuously; each completion is a new access.
      do_reset();
`ifdef SRAM_ARB_FIXED_PRIORITY_EN
      exp_order = '{0, 0, 0, 0};
`else
      exp_order = '{0, 1, 0, 1};
`endif
      a_addr[0] = 18'h00010; a_rd[0] = 1;
      b_addr[0] = 18'h3FFFF; b_rd[0] = 1;
      for (int c = 0; c < 60; c++) begin
         #1;
         if (!a_wait[0]) order.push_back(0);
         if (!b_wait[0]) order.push_back(1);
         if (order.size() >= 4) break;
         @(posedge clk); #1;
      end
      chk("alt_count", 32'(order.size()), 32'd4);
      for (int i = 0; i < 4 && i < order.size(); i++) chk("alt_order", 32'(order[i]), 32'(exp_order[i]));
      @(posedge clk); #1;
      idle_all();
      chk("alt_a_rdata", 32'(a_rdat[0]), 32'hBEEF);
`ifdef SRAM_ARB_FIXED_PRIORITY_EN
      chk("alt_b_rdata", 32'(b_rdat[0]), 32'h0000);
`else
      chk("alt_b_rdata", 32'(b_rdat[0]), 32'hA5AB);
`endif

      // Reset asserted mid-WAIT of an A read.
      a_addr[0] = 18'h00010; a_rd[0] = 1;
      @(posedge clk); #1;
      @(posedge clk); #1;
      chk("wait_cs", 32'(s_cs[0]), 32'd1);
      #2 reset_n = 1'b0;
      #1;
      chk("mid_rst_cs", 32'(s_cs[0]), 32'd0);
      chk("mid_rst_rd", 32'(s_rd[0]), 32'd0);
      chk("mid_rst_a_rdata", 32'(a_rdat[0]), 32'd0);
      chk("mid_rst_a_wait", 32'(a_wait[0]), 32'd1);
      a_rd[0] = 0;
      @(posedge clk);
      @(negedge clk) reset_n = 1'b1;
      @(posedge clk); #1;
      for (int d = 0; d < NDUT; d++) begin held_a[d] = '0; held_b[d] = '0; end
      chk("no_replay_cs", 32'(s_cs[0]), 32'd0);
      chk("no_replay_wait", 32'(a_wait[0]), 32'd0);
      v = '{0, 1'b0, 1'b0, 1'b0, 18'h00010, 2'b11, 16'h0000, 3, 16'hBEEF};
      run_vec(v);

      rand_run(0, 250);
      rand_run(1, 250);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/sram_arbiter.md
Name: sram_arbiter

Overview:
- Two-requester arbiter that shares one SRAM_Controller instance in the SOPC system.
- Requester A is typically the Nios data master; requester B is a streaming client such as a VGA or DMA reader.
- Sequences each granted access through the controller's registered read path and returns read data with Avalon-style waitrequest handshakes.
- Arbitration is round-robin by default.

Parameters:
- ADDR_W, 18, word address width, matching the SRAM_ADDR width.
- DATA_W, 16, data width.
- READ_LATENCY, 1, clk cycles from downstream read issue until downstream read_data is valid; legal range 1..4.

Ports:
- clk  input  1  system clock
- reset_n  input  1  reset; one clock, reset is asynchronous and active-low
- a_address  input  ADDR_W  requester A word address
- a_byte_enable  input  2  requester A byte lanes
- a_read  input  1  requester A read request
- a_write  input  1  requester A write request
- a_write_data  input  DATA_W  requester A write data
- a_read_data  output  DATA_W  requester A read data
- a_waitrequest  output  1  requester A stall
- b_*  (same seven signals as a_*)  requester B
- s_address  output  ADDR_W  to controller address
- s_chipselect  output  1  to controller chipselect
- s_byte_enable  output  2  to controller byte_enable
- s_read  output  1  to controller read
- s_write  output  1  to controller write
- s_write_data  output  DATA_W  to controller write_data
- s_read_data  input  DATA_W  from controller read_data
- grant_b  output  1  debug: 1 while B owns the bus, 0 for A or idle

Behaviour:
- Reset (asynchronous, reset_n low):
  - State IDLE; all s_* outputs 0; a/b_read_data 0; grant_b 0; last-winner register = B.
  - Any in-flight access is abandoned; nothing is replayed after reset.
- waitrequest:
  - x_waitrequest = (x_read | x_write) & ~(this cycle completes x's access).
  - It is 0 whenever x is not requesting.
  - Requesters hold address, data and strobes stable while waitrequest is 1.
- Read and write asserted together on one requester: treated as a write.
- FSM states:
  - IDLE: evaluate requests. If none, stay. If exactly one, grant it. If both, grant the requester that is not the last winner. Register the granted requester's address, byte_enable, write_data and the op → ISSUE.
  - ISSUE (1 cycle): s_chipselect=1; s_read or s_write=1 per op; s_address and s_byte_enable from the registered values.
    - Write: the granted waitrequest is 0 this cycle (completion), last winner updated → IDLE.
    - Read: load the latency counter with READ_LATENCY-1 → WAIT.
  - WAIT: s_chipselect=1, s_read=0, s_write=0. Decrement the counter. When the counter is 0, capture s_read_data into the granted requester's read_data register → RESP.
  - RESP (1 cycle): the granted waitrequest is 0 and x_read_data holds the captured word; last winner updated → IDLE.
- Latency from request seen in IDLE:
  - Write completes in cycle 1, i.e. 2 cycles total.
  - Read completes in cycle 2+READ_LATENCY.
- One idle bubble always separates accesses.
- x_read_data holds its last captured value until the next read for x; the other requester's value is untouched.
- A requester that drops its strobe mid-access violates protocol. The access still finishes and the result is discarded.
- Grant changes only in IDLE; the non-granted requester sees waitrequest=1 throughout.

Optional Feature:
- SRAM_ARB_FIXED_PRIORITY_EN
  - Defined: on a tie, A always wins; the last-winner register is not implemented.
  - Undefined: round-robin as described above.

Decomposition:
- Package sram_arb_pkg:
  - state enum (IDLE, ISSUE, WAIT, RESP)
  - op enum (OP_RD, OP_WR)
  - requester ID constants (REQ_A=0, REQ_B=1)
- One natural sub-module, sram_arb_pick: combinational winner select from (a_req, b_req, last_winner), macro-aware.

Test Plan:
- After reset, A writes 0xBEEF to 0x00010, be=2'b11 → ISSUE one cycle later: s_write=1, s_address=0x00010, s_write_data=0xBEEF; a_waitrequest low in that cycle only.
- A reads 0x00010 with s_read_data model returning 0xBEEF after READ_LATENCY=1 → a_waitrequest low and a_read_data=0xBEEF in cycle 3; b_read_data unchanged.
- A and B request reads in the same cycle, repeatedly → grants alternate A,B,A,B. With SRAM_ARB_FIXED_PRIORITY_EN, A always wins while both are requesting.
- B byte write, be=2'b01, data 0x12AB to 0x3FFFF (top address) → s_byte_enable=2'b01, s_address=0x3FFFF; grant_b=1 during ISSUE.
- reset_n pulsed low during WAIT of an A read → s_chipselect and s_read drop to 0 asynchronously, state IDLE, a_read_data=0. A re-requests and completes normally.
- READ_LATENCY=3, B reads → b_waitrequest low in cycle 5 and data captured from the third WAIT cycle.
